timex_pager: RTL and testbench

Clocked, parametrised paging controller for the Timex FDD interface on the ZX Spectrum edge connector. It replaces the unclocked page flip-flop with a synchronised, glitch-filtered state machine. Page changes are committed only at the end of a memory cycle. The block adds a software control register for forced paging and paging lock, a ROM write-protect, and parametrised memory map and I/O ports. It drives the ZX ROM disable, the interface ROM/RAM selects and the FDD data-port strobes.

---
 rtl/timex_pkg.sv | 36 +++
 rtl/timex_bus_sync.sv | 41 ++++
 rtl/timex_pager.sv | 151 +++++++++++++++
 tb/tb_timex_pager.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/timex_pkg.sv
// Shared types and defaults for the Timex FDD interface paging controller.
// Holds the pager state encoding, default memory map / port constants and control-bit indices.
package timex_pkg;

    typedef enum logic [1:0] {
        ST_OUT      = 2'd0,
        ST_PEND_IN  = 2'd1,
        ST_IN       = 2'd2,
        ST_PEND_OUT = 2'd3
    } pager_state_t;

    localparam int          DEF_ROM_AW    = 12;
    localparam int          DEF_RAM_AW    = 11;
    localparam logic [15:0] DEF_RAM_BASE  = 16'h2000;
    localparam logic [15:0] DEF_PAGEIN_A0 = 16'h0000;
    localparam logic [15:0] DEF_PAGEIN_A1 = 16'h0008;
    localparam logic [15:0] DEF_PAGEOUT_A = 16'h0604;
    localparam logic [7:0]  DEF_DATA_PORT = 8'hEF;
    localparam logic [7:0]  DEF_CTRL_PORT = 8'hEE;

    localparam int CTRL_FORCE = 0;
    localparam int CTRL_LOCK  = 1;

    // Bit positions of the Z80 strobes in the synchroniser bank.
    localparam int N_STROBES = 5;
    localparam int SB_MREQ   = 0;
    localparam int SB_IORQ   = 1;
    localparam int SB_RD     = 2;
    localparam int SB_WR     = 3;
    localparam int SB_M1     = 4;

    function automatic logic port_hit(input logic [15:0] addr, input logic [7:0] port);
        return addr[7:0] == port;
    endfunction

endpackage

// File: rtl/timex_bus_sync.sv
// Synchroniser, low-level glitch filter and rising-edge detector for one active-low Z80 strobe.
// low_ok asserts once the synchronised strobe has been low for MIN_LOW consecutive samples.
module timex_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic low_ok,
    output logic rise
);

    localparam int CW = $clog2(MIN_LOW + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic [CW-1:0]          low_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg    <= '1;
            prev_reg    <= 1'b1;
            low_cnt_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            if (sync_reg[SYNC_STAGES-1]) begin
                low_cnt_reg <= '0;
            end else if (low_cnt_reg != CW'(MIN_LOW)) begin
                low_cnt_reg <= low_cnt_reg + 1'b1;
            end
        end
    end

    assign level  = sync_reg[SYNC_STAGES-1];
    assign low_ok = (low_cnt_reg == CW'(MIN_LOW)) && !level;
    assign rise   = level && !prev_reg;

endmodule

// File: rtl/timex_pager.sv
// Clocked paging controller for the Timex FDD interface: commits page changes at cycle end,
// adds a control register for forced paging/lock, and decodes the interface ROM/RAM and data port.
module timex_pager
    import timex_pkg::*;
#(
    parameter int          ROM_AW      = DEF_ROM_AW,
    parameter logic [15:0] RAM_BASE    = DEF_RAM_BASE,
    parameter int          RAM_AW      = DEF_RAM_AW,
    parameter logic [15:0] PAGEIN_A0   = DEF_PAGEIN_A0,
    parameter logic [15:0] PAGEIN_A1   = DEF_PAGEIN_A1,
    parameter logic [15:0] PAGEOUT_A   = DEF_PAGEOUT_A,
    parameter logic [7:0]  DATA_PORT   = DEF_DATA_PORT,
    parameter logic [7:0]  CTRL_PORT   = DEF_CTRL_PORT,
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_LOW     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        nIORQ,
    input  logic        nMREQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    output logic        nZX_ROMCS,
    output logic        nROM_CS,
    output logic        nRAM_CS,
    output logic        LS273,
    output logic        nLS244,
    output logic        PAGED,
    output logic        LOCKED
);

    // An illegal map (page-out colliding with page-in, oversize regions) keeps the interface inert.
    localparam bit CFG_OK = (ROM_AW > 0) && (ROM_AW <= 14) && (RAM_AW > 0) && (RAM_AW <= 14) &&
                            (PAGEOUT_A != PAGEIN_A0) && (PAGEOUT_A != PAGEIN_A1) &&
                            (SYNC_STAGES >= 2) && (MIN_LOW >= 1);

    logic [N_STROBES-1:0] pins;
    logic [N_STROBES-1:0] lvl;
    logic [N_STROBES-1:0] low_ok;
    logic [N_STROBES-1:0] rise;

    assign pins = {nM1, nWR, nRD, nIORQ, nMREQ};

    generate
        for (genvar gi = 0; gi < N_STROBES; gi++) begin : g_sync
            timex_bus_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .MIN_LOW     (MIN_LOW)
            ) u_sync (
                .clk    (CLK),
                .rst    (RST),
                .pin    (pins[gi]),
                .level  (lvl[gi]),
                .low_ok (low_ok[gi]),
                .rise   (rise[gi])
            );
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{lvl[SB_MREQ], lvl[SB_IORQ], lvl[SB_RD], lvl[SB_WR], low_ok[SB_M1],
                           rise[SB_RD], rise[SB_WR], rise[SB_M1], D[7:2]};

    pager_state_t state_reg, state_next;
    logic         locked_reg, locked_next;
    logic         paged_reg;
    logic         ctrl_valid_reg, ctrl_valid_next;
    logic [1:0]   ctrl_data_reg, ctrl_data_next;
    logic         mem_qual_prev_reg, io_qual_prev_reg;

    logic mem_qual, mem_start, io_qual, io_start, is_fetch, pagein_hit, pageout_hit, ctrl_hit;

    assign mem_qual    = low_ok[SB_MREQ] && low_ok[SB_RD];
    assign mem_start   = mem_qual && !mem_qual_prev_reg;
    assign io_qual     = low_ok[SB_IORQ] && low_ok[SB_WR];
    assign io_start    = io_qual && !io_qual_prev_reg;
    assign is_fetch    = !lvl[SB_M1];
    assign pagein_hit  = (A == PAGEIN_A0) || (A == PAGEIN_A1);
    assign pageout_hit = (A == PAGEOUT_A);
    assign ctrl_hit    = io_start && port_hit(A, CTRL_PORT);

    always_comb begin
        state_next      = state_reg;
        locked_next     = locked_reg;
        ctrl_valid_next = ctrl_valid_reg;
        ctrl_data_next  = ctrl_data_reg;

        case (state_reg)
            ST_OUT:      if (CFG_OK && mem_start && !locked_reg && is_fetch && pagein_hit)
                             state_next = ST_PEND_IN;
            ST_PEND_IN:  if (rise[SB_MREQ]) state_next = ST_IN;
            ST_IN:       if (CFG_OK && mem_start && !locked_reg && pageout_hit)
                             state_next = ST_PEND_OUT;
            ST_PEND_OUT: if (rise[SB_MREQ]) state_next = ST_OUT;
            default:     state_next = ST_OUT;
        endcase

        if (ctrl_hit) begin
            ctrl_valid_next = 1'b1;
            ctrl_data_next  = D[1:0];
        end

        // Forced paging wins over any pending automatic change; no memory cycle can be open here.
        if (rise[SB_IORQ]) begin
            ctrl_valid_next = 1'b0;
            if (ctrl_valid_reg) begin
                locked_next = ctrl_data_reg[CTRL_LOCK];
                if (ctrl_data_reg[CTRL_FORCE])
                    state_next = ST_IN;
                else if (!ctrl_data_reg[CTRL_LOCK])
                    state_next = ST_OUT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg         <= ST_OUT;
            locked_reg        <= 1'b0;
            paged_reg         <= 1'b0;
            ctrl_valid_reg    <= 1'b0;
            ctrl_data_reg     <= 2'b00;
            mem_qual_prev_reg <= 1'b0;
            io_qual_prev_reg  <= 1'b0;
        end else begin
            state_reg         <= state_next;
            locked_reg        <= locked_next;
            paged_reg         <= (state_next == ST_IN) || (state_next == ST_PEND_OUT);
            ctrl_valid_reg    <= ctrl_valid_next;
            ctrl_data_reg     <= ctrl_data_next;
            mem_qual_prev_reg <= mem_qual;
            io_qual_prev_reg  <= io_qual;
        end
    end

    logic rom_region, ram_region;
    assign rom_region = (A[15:14] == 2'b00) && (A < RAM_BASE);
    assign ram_region = (A >= RAM_BASE) && (A <= 16'h3FFF);

    assign PAGED     = paged_reg;
    assign LOCKED    = locked_reg;
    assign nZX_ROMCS = paged_reg;
    assign nROM_CS   = !(CFG_OK && paged_reg && !RST && !nMREQ && !nRD && rom_region);
    assign nRAM_CS   = !(CFG_OK && paged_reg && !RST && !nMREQ && ram_region);
    assign LS273     = !nIORQ && !nWR && port_hit(A, DATA_PORT);
    assign nLS244    = !(!nIORQ && !nRD && port_hit(A, DATA_PORT));

endmodule

// File: tb/tb_timex_pager.sv
// Scoreboard bench for timex_pager: bus tasks push expected outputs from a paging model,
// and each observation pops the oldest expectation and compares it against the DUT.
module tb_timex_pager;

    localparam int SYNC = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D = 8'h00;
    logic        nIORQ = 1'b1, nMREQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nM1 = 1'b1;
    logic        nZX_ROMCS, nROM_CS, nRAM_CS, LS273, nLS244, PAGED, LOCKED;

    always #5 CLK = ~CLK;

    timex_pager dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .D         (D),
        .nIORQ     (nIORQ),
        .nMREQ     (nMREQ),
        .nRD       (nRD),
        .nWR       (nWR),
        .nM1       (nM1),
        .nZX_ROMCS (nZX_ROMCS),
        .nROM_CS   (nROM_CS),
        .nRAM_CS   (nRAM_CS),
        .LS273     (LS273),
        .nLS244    (nLS244),
        .PAGED     (PAGED),
        .LOCKED    (LOCKED)
    );

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   paged_m = 1'b0;
    bit   locked_m = 1'b0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic got);
        exp_t e;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: empty queue, got %b expected an entry", got);
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        check_bit(e.tag, got, e.exp);
    endtask

    task automatic mem_cycle(input logic [15:0] addr, input bit m1, input bit wr, input bit timed);
        bit old_paged;
        @(negedge CLK);
        A   = addr;
        nM1 = m1 ? 1'b0 : 1'b1;
        @(negedge CLK);
        nMREQ = 1'b0;
        if (wr) nWR = 1'b0;
        else    nRD = 1'b0;
        push_exp($sformatf("mem_%h_rom", addr), !(paged_m && !wr && addr < 16'h2000));
        push_exp($sformatf("mem_%h_ram", addr), !(paged_m && addr >= 16'h2000 && addr <= 16'h3FFF));
        push_exp($sformatf("mem_%h_paged_mid", addr), paged_m);
        repeat (8) @(negedge CLK);
        observe(nROM_CS);
        observe(nRAM_CS);
        observe(PAGED);
        nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
        old_paged = paged_m;
        if (!wr && !locked_m) begin
            if (!paged_m && m1 && (addr == 16'h0000 || addr == 16'h0008)) paged_m = 1'b1;
            else if (paged_m && addr == 16'h0604)                          paged_m = 1'b0;
        end
        if (timed) begin
            push_exp("commit_hold", old_paged);
            repeat (SYNC) @(posedge CLK);
            @(negedge CLK);
            observe(PAGED);
            push_exp("commit_edge", paged_m);
            @(posedge CLK);
            @(negedge CLK);
            observe(PAGED);
        end
        repeat (6) @(negedge CLK);
        push_exp($sformatf("mem_%h_paged_end", addr), paged_m);
        observe(PAGED);
        $display("mem A=%h m1=%0b wr=%0b -> PAGED=%0b nROM_CS/nRAM_CS sampled", addr, m1, wr, PAGED);
    endtask

    task automatic io_cycle(input logic [7:0] port, input logic [7:0] data, input bit wr);
        @(negedge CLK);
        A = {8'h5A, port};
        D = data;
        @(negedge CLK);
        nIORQ = 1'b0;
        if (wr) nWR = 1'b0;
        else    nRD = 1'b0;
        push_exp($sformatf("io_%h_ls273", port), wr && port == 8'hEF);
        push_exp($sformatf("io_%h_nls244", port), !(!wr && port == 8'hEF));
        repeat (8) @(negedge CLK);
        observe(LS273);
        observe(nLS244);
        if (wr) begin
            nWR = 1'b1;
            push_exp($sformatf("io_%h_ls273_off", port), 1'b0);
            repeat (2) @(negedge CLK);
            observe(LS273);
        end
        nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
        if (wr && port == 8'hEE) begin
            if (data[0])       paged_m = 1'b1;
            else if (!data[1]) paged_m = 1'b0;
            locked_m = data[1];
        end
        repeat (6) @(negedge CLK);
        push_exp($sformatf("io_%h_paged", port), paged_m);
        push_exp($sformatf("io_%h_locked", port), locked_m);
        observe(PAGED);
        observe(LOCKED);
        $display("io port=%h D=%h wr=%0b -> PAGED=%0b LOCKED=%0b", port, data, wr, PAGED, LOCKED);
    endtask

    task automatic glitch_fetch(input logic [15:0] addr);
        @(negedge CLK);
        A = addr; nM1 = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        nMREQ = 1'b0;
        @(negedge CLK);
        nMREQ = 1'b1;
        repeat (2) @(negedge CLK);
        nRD = 1'b1; nM1 = 1'b1;
        repeat (6) @(negedge CLK);
        push_exp("glitch_paged", paged_m);
        observe(PAGED);
        $display("glitch A=%h -> PAGED=%0b", addr, PAGED);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        push_exp("rst_paged", 1'b0);
        push_exp("rst_locked", 1'b0);
        push_exp("rst_zxromcs", 1'b0);
        push_exp("rst_romcs", 1'b1);
        push_exp("rst_ramcs", 1'b1);
        observe(PAGED); observe(LOCKED); observe(nZX_ROMCS); observe(nROM_CS); observe(nRAM_CS);
        $display("reset idle -> PAGED=%0b LOCKED=%0b", PAGED, LOCKED);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        mem_cycle(16'h0000, 1'b1, 1'b0, 1'b0);

        // Reset asserted in the middle of a fetch while paged in.
        @(negedge CLK);
        A = 16'h0000; nM1 = 1'b0;
        @(negedge CLK);
        nMREQ = 1'b0; nRD = 1'b0;
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        paged_m = 1'b0; locked_m = 1'b0;
        @(negedge CLK);
        push_exp("midrst_paged", 1'b0);
        push_exp("midrst_zxromcs", 1'b0);
        push_exp("midrst_romcs", 1'b1);
        observe(PAGED); observe(nZX_ROMCS); observe(nROM_CS);
        A = 16'h2000;
        @(negedge CLK);
        push_exp("midrst_ramcs", 1'b1);
        observe(nRAM_CS);
        nMREQ = 1'b1; nRD = 1'b1; nM1 = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        push_exp("midrst_after", 1'b0);
        observe(PAGED);
        $display("reset mid-fetch -> PAGED=%0b", PAGED);

        mem_cycle(16'h0008, 1'b1, 1'b0, 1'b0);
        mem_cycle(16'h0123, 1'b0, 1'b0, 1'b0);
        mem_cycle(16'h2005, 1'b0, 1'b1, 1'b0);
        mem_cycle(16'h0100, 1'b0, 1'b1, 1'b0);
        mem_cycle(16'h2100, 1'b0, 1'b0, 1'b0);
        mem_cycle(16'h0604, 1'b0, 1'b0, 1'b1);
        mem_cycle(16'h0000, 1'b0, 1'b0, 1'b0);
        mem_cycle(16'h0000, 1'b1, 1'b0, 1'b0);
        mem_cycle(16'h0604, 1'b1, 1'b0, 1'b0);

        io_cycle(8'hEE, 8'h03, 1'b1);
        mem_cycle(16'h0604, 1'b0, 1'b0, 1'b0);
        io_cycle(8'hEE, 8'h00, 1'b1);
        io_cycle(8'hEE, 8'h02, 1'b1);
        mem_cycle(16'h0000, 1'b1, 1'b0, 1'b0);
        io_cycle(8'hEE, 8'h00, 1'b1);

        glitch_fetch(16'h0000);
        io_cycle(8'hEF, 8'h55, 1'b1);
        io_cycle(8'hEF, 8'h00, 1'b0);
        io_cycle(8'hEE, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
